// File: rtl/cp0_unit_if.sv
// Bus between the M-stage pipeline logic and CP0: exception sources, the
// mtc0/mfc0 port, eret and the trap/redirect outputs.
interface cp0_unit_if;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    modport master (
        output en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
        input  cp0_out, req, handler_pc, epc_out
    );

    modport slave (
        input  en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
        output cp0_out, req, handler_pc, epc_out
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller: decides traps at the M stage,
// records SR/Cause/EPC, serves mfc0/mtc0 and clears EXL on eret.
module cp0_unit (
    input  logic       clk,
    input  logic       reset,
    cp0_unit_if.slave  bus
);
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [4:0]  ADDR_SR    = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE = 5'd13;
    localparam logic [4:0]  ADDR_EPC   = 5'd14;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        trap;
    logic [31:0] vpc_aligned;
    logic [31:0] trap_epc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req     = sr_ie & ~sr_exl & (|(sr_im & bus.hw_int));
    assign exc_req     = ~sr_exl & (bus.exc_code_in != 5'd0);
    assign trap        = int_req | exc_req;
    assign vpc_aligned = {bus.vpc[31:2], 2'b00};
    // Delay-slot traps restart at the branch; subtraction wraps naturally.
    assign trap_epc    = bus.bd_in ? (vpc_aligned - 32'd4) : vpc_aligned;

    assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= bus.hw_int;
            if (trap) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? 5'd0 : bus.exc_code_in;
                cause_bd  <= bus.bd_in;
                epc       <= trap_epc;
            end else begin
                if (bus.en) begin
                    case (bus.cp0_addr)
                        ADDR_SR: begin
                            sr_im  <= bus.cp0_in[15:10];
                            sr_exl <= bus.cp0_in[1];
                            sr_ie  <= bus.cp0_in[0];
                        end
                        ADDR_EPC: epc <= {bus.cp0_in[31:2], 2'b00};
                        default: ;
                    endcase
                end
                // Later assignment wins, so eret overrides a same-cycle SR write.
                if (bus.exl_clr) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.cp0_out = 32'd0;
        case (bus.cp0_addr)
            ADDR_SR:    bus.cp0_out = sr_word;
            ADDR_CAUSE: bus.cp0_out = cause_word;
            ADDR_EPC:   bus.cp0_out = epc;
            default:    bus.cp0_out = 32'd0;
        endcase
    end

    assign bus.req        = trap;
    assign bus.handler_pc = HANDLER_PC;
    assign bus.epc_out    = (bus.en && bus.cp0_addr == ADDR_EPC)
                          ? {bus.cp0_in[31:2], 2'b00} : epc;
endmodule

// File: tb/tb_cp0_unit.sv
// Directed test of cp0_unit: traps, priority, EXL masking, eret, mtc0/mfc0, reset.
module tb_cp0_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    cp0_unit_if bus ();

    cp0_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_addr = a;
        #1;
        check(tag, bus.cp0_out, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset           = 1'b0;
        bus.en          = 1'b0;
        bus.cp0_addr    = 5'd0;
        bus.cp0_in      = 32'd0;
        bus.vpc         = 32'd0;
        bus.bd_in       = 1'b0;
        bus.exc_code_in = 5'd0;
        bus.hw_int      = 6'd0;
        bus.exl_clr     = 1'b0;

        repeat (2) step();
        check("rst_req", {31'd0, bus.req}, 32'd0);
        check("rst_handler", bus.handler_pc, 32'h0000_4180);
        check("rst_epc_out", bus.epc_out, 32'd0);
        chk_reg("rst_sr", 5'd12, 32'd0);
        chk_reg("rst_cause", 5'd13, 32'd0);
        chk_reg("rst_epc", 5'd14, 32'd0);
        reset = 1'b1;
        step();

        // Overflow trap
        bus.exc_code_in = 5'd12; bus.vpc = 32'h3010; bus.bd_in = 1'b0;
        #1 check("ov_req", {31'd0, bus.req}, 32'd1);
        step();
        bus.exc_code_in = 5'd0;
        chk_reg("ov_cause", 5'd13, 32'h0000_0030);
        chk_reg("ov_epc", 5'd14, 32'h0000_3010);
        chk_reg("ov_sr", 5'd12, 32'h0000_0002);

        // EXL masks, eret re-enables
        bus.exc_code_in = 5'd4;
        #1 check("exl_mask_req", {31'd0, bus.req}, 32'd0);
        bus.exc_code_in = 5'd0; bus.exl_clr = 1'b1;
        step();
        bus.exl_clr = 1'b0;
        chk_reg("eret_sr", 5'd12, 32'd0);
        bus.exc_code_in = 5'd4;
        #1 check("eret_req", {31'd0, bus.req}, 32'd1);

        // Delay-slot trap
        bus.exc_code_in = 5'd10; bus.vpc = 32'h3024; bus.bd_in = 1'b1;
        step();
        bus.exc_code_in = 5'd0; bus.bd_in = 1'b0;
        chk_reg("bd_cause", 5'd13, 32'h8000_0028);
        chk_reg("bd_epc", 5'd14, 32'h0000_3020);
        bus.exl_clr = 1'b1;
        step();
        bus.exl_clr = 1'b0;

        // Interrupt beats exception
        bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_in = 32'h0000_0401;
        step();
        bus.en = 1'b0;
        chk_reg("sr_wr", 5'd12, 32'h0000_0401);
        bus.hw_int = 6'b000001; bus.exc_code_in = 5'd12; bus.vpc = 32'h4000;
        #1 check("int_req", {31'd0, bus.req}, 32'd1);
        step();
        bus.hw_int = 6'd0; bus.exc_code_in = 5'd0;
        chk_reg("int_cause", 5'd13, 32'h0000_0400);
        chk_reg("int_sr", 5'd12, 32'h0000_0403);
        bus.exl_clr = 1'b1;
        step();
        bus.exl_clr = 1'b0;
        chk_reg("int_cause_ip_clr", 5'd13, 32'd0);

        // IM clear: same inputs take the exception
        bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_in = 32'h0000_0001;
        step();
        bus.en = 1'b0;
        bus.hw_int = 6'b000001; bus.exc_code_in = 5'd12;
        step();
        bus.hw_int = 6'd0; bus.exc_code_in = 5'd0;
        chk_reg("masked_cause", 5'd13, 32'h0000_0430);
        bus.exl_clr = 1'b1;
        step();
        bus.exl_clr = 1'b0;

        // EPC write with forwarding
        bus.en = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_in = 32'h0000_3007;
        #1 check("epc_fwd", bus.epc_out, 32'h0000_3004);
        step();
        bus.en = 1'b0;
        chk_reg("epc_wr", 5'd14, 32'h0000_3004);
        check("epc_out_reg", bus.epc_out, 32'h0000_3004);

        // Cause is read-only
        bus.en = 1'b1; bus.cp0_addr = 5'd13; bus.cp0_in = 32'hFFFF_FFFF;
        step();
        bus.en = 1'b0;
        chk_reg("cause_ro", 5'd13, 32'h0000_0030);

        // mtc0 concurrent with a trap is dropped
        bus.en = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_in = 32'h0000_1234;
        bus.exc_code_in = 5'd5; bus.vpc = 32'h5000;
        #1 check("drop_req", {31'd0, bus.req}, 32'd1);
        step();
        bus.en = 1'b0; bus.exc_code_in = 5'd0;
        chk_reg("drop_epc", 5'd14, 32'h0000_5000);
        chk_reg("drop_cause", 5'd13, 32'h0000_0014);
        bus.exl_clr = 1'b1;
        step();
        bus.exl_clr = 1'b0;

        // EPC wrap at vpc 0 in a delay slot
        bus.exc_code_in = 5'd4; bus.vpc = 32'd0; bus.bd_in = 1'b1;
        step();
        bus.exc_code_in = 5'd0; bus.bd_in = 1'b0;
        chk_reg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        chk_reg("wrap_cause", 5'd13, 32'h8000_0010);

        // eret with same-cycle SR write: EXL clear wins
        bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_in = 32'h0000_FC03; bus.exl_clr = 1'b1;
        step();
        bus.en = 1'b0; bus.exl_clr = 1'b0;
        chk_reg("eret_sr_wr", 5'd12, 32'h0000_FC01);

        // Trap then asynchronous reset mid-cycle
        bus.hw_int = 6'b100000;
        step();
        chk_reg("pre_rst_sr", 5'd12, 32'h0000_FC03);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, bus.req}, 32'd0);
        check("mid_rst_epc_out", bus.epc_out, 32'd0);
        chk_reg("mid_rst_sr", 5'd12, 32'd0);
        chk_reg("mid_rst_cause", 5'd13, 32'd0);
        chk_reg("mid_rst_epc", 5'd14, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline: the consumer of the ALU overflow flag and every other exception source. Samples exception codes and hardware interrupts at the M stage and decides whether to take a trap. On a trap it records EPC, Cause and BD and raises a one-cycle flush request. It also serves mfc0/mtc0 and clears exception level on eret.

## Interface
- HANDLER_PC, 32'h0000_4180: exception entry address driven on `handler_pc`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `en`  in  1  mtc0 write enable (M stage).
- `cp0_addr`  in  5  register number for mfc0/mtc0 (12 SR, 13 Cause, 14 EPC).
- `cp0_in`  in  32  mtc0 write data.
- `cp0_out`  out  32  mfc0 read data, combinational.
- `vpc`  in  32  PC of the M-stage instruction, or of its bubble.
- `bd_in`  in  1  M-stage instruction is in a branch delay slot.
- `exc_code_in`  in  5  pending exception code (0 = none; 4 AdEL, 5 AdES, 10 RI, 12 Ov).
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `exl_clr`  in  1  eret in M stage.
- `req`  out  1  take trap this cycle; flush pipeline and redirect PC.
- `handler_pc`  out  32  constant HANDLER_PC.
- `epc_out`  out  32  current EPC, with same-cycle mtc0 forwarding.

## Operation
- SR (12): IM = bits[15:10], EXL = bit[1], IE = bit[0]. Other bits read 0 and ignore writes.
- Cause (13): BD = bit[31], IP = bits[15:10], ExcCode = bits[6:2]. Other bits read 0. Cause is not writable by mtc0.
- EPC (14): 32-bit register, writable by mtc0.
- Reads of any other address return 0.
- int_req = IE & ~EXL & |(IM & hw_int).
- exc_req = ~EXL & (exc_code_in != 0).
- `req` = int_req | exc_req. It is combinational from the current register state and inputs.
- Priority: an interrupt beats a synchronous exception. If both are pending, ExcCode is 0.
- On a clock edge with `req` = 1, the following updates happen together:
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : exc_code_in.
  - BD <= bd_in.
  - EPC <= bd_in ? {vpc[31:2],2'b00} - 4 : {vpc[31:2],2'b00}.
- When `req` = 1, an mtc0 in the same cycle is discarded.
- When `req` = 0 and `en` = 1, the register selected by `cp0_addr` is written. EPC writes are stored with bits[1:0] forced to 0.
- When `req` = 0 and `exl_clr` = 1, EXL <= 0 on the next edge.
  - An mtc0 to SR in the same cycle is applied first; the EXL clear then overrides bit 1.
- Cause.IP <= hw_int on every edge, whether or not a trap is taken.
- `epc_out`: when `en` = 1 and `cp0_addr` = 14, it shows the incoming `cp0_in` word-aligned (forwarding for eret); otherwise it shows the EPC register.
- EPC subtraction wraps modulo 2^32 (vpc = 0 with bd_in = 1 gives 32'hFFFF_FFFC).

## Timing
- Reset (reset = 0, asynchronous): SR, Cause and EPC all clear to 0. As a result `req` = 0, `cp0_out` = 0, `epc_out` = 0, and `handler_pc` = HANDLER_PC.
- Deasserting reset takes effect at the first rising edge after release.
- `req` and `cp0_out` have zero latency (combinational).
- Register updates are visible on the cycle after the edge.
- After a trap, EXL = 1 masks all further requests until an eret has retired, i.e. one edge after `exl_clr`.
- A `hw_int` pulse lasting less than one cycle and missing the edge is not recorded in IP. `req` still sees it combinationally.
- Reset asserted mid-trap overrides everything; no partial update is retained.

## Test plan
- Overflow trap: SR = 0, exc_code_in = 12, vpc = 0x3010, bd_in = 0 -> `req` = 1; next cycle EPC = 0x3010, ExcCode = 12, EXL = 1, BD = 0.
- Delay-slot trap: exc_code_in = 10, vpc = 0x3024, bd_in = 1 -> EPC = 0x3020, BD = 1, Cause = 0x8000_0028.
- Interrupt priority and masking:
  - SR = 0x0000_0401, hw_int = 6'b000001, exc_code_in = 12 -> `req` = 1, ExcCode = 0.
  - With SR = 0x0000_0001 (IM clear) the same inputs give ExcCode = 12.
- EXL masking / eret: after a trap, drive exc_code_in = 4 -> `req` = 0. Then `exl_clr` = 1 -> next cycle SR[1] = 0, and exc_code_in = 4 now raises `req`.
- mtc0/mfc0:
  - Write EPC = 0x0000_3007 -> `epc_out` = 0x3004 the same cycle; reads 0x3004 afterwards.
  - Write Cause = 0xFFFF_FFFF -> Cause unchanged.
  - A write concurrent with `req` = 1 is dropped.
- Reset: complete a trap, then pull reset low mid-cycle -> SR, Cause and EPC read 0 immediately, and `req` = 0 with hw_int active.
